// File: rtl/wallace_acc_if.sv
// Product stream in / dot-product result out bundle for wallace_acc.
// master drives products and takes results; slave is the accumulator.
interface wallace_acc_if #(
    parameter int unsigned ACC_W = 40,
    parameter int unsigned CNT_W = 8
);
    logic [31:0]      prod;
    logic             prod_valid;
    logic             prod_last;
    logic             prod_ready;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] acc_count;
    logic             acc_ovf;
    logic             acc_valid;
    logic             acc_ready;

    modport master (
        output prod, prod_valid, prod_last, acc_ready,
        input  prod_ready, acc, acc_count, acc_ovf, acc_valid
    );

    modport slave (
        input  prod, prod_valid, prod_last, acc_ready,
        output prod_ready, acc, acc_count, acc_ovf, acc_valid
    );
endinterface

// File: rtl/wallace_acc.sv
// Streaming accumulator: sums prod_last-delimited vectors of 32-bit products
// and presents each finished sum on a registered valid/ready output.
module wallace_acc #(
    parameter int unsigned ACC_W = 40,
    parameter int unsigned CNT_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    wallace_acc_if.slave  bus
);
    typedef enum logic {COLLECT, HOLD} state_t;

    state_t           state;
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] cnt;
    logic             ovf;

    logic [ACC_W-1:0] acc_r;
    logic [CNT_W-1:0] acc_count_r;
    logic             acc_ovf_r;
    logic             acc_valid_r;

    logic             accept;
    logic [ACC_W:0]   sum_ext;
    logic [ACC_W-1:0] sum_nxt;
    logic             carry;
    logic             cnt_sat;
    logic [CNT_W-1:0] cnt_nxt;
    logic             ovf_nxt;

    // Running sum is cleared on entry to HOLD, so a product accepted while
    // the old result retires naturally starts a fresh vector.
    always_comb begin
        bus.prod_ready = (state == COLLECT) || bus.acc_ready;
        accept         = bus.prod_valid && bus.prod_ready;
        sum_ext        = {1'b0, sum} + (ACC_W+1)'(bus.prod);
        sum_nxt        = sum_ext[ACC_W-1:0];
        carry          = sum_ext[ACC_W];
        cnt_sat        = &cnt;
        cnt_nxt        = cnt_sat ? cnt : cnt + 1'b1;
        ovf_nxt        = ovf || carry || cnt_sat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= COLLECT;
            sum         <= '0;
            cnt         <= '0;
            ovf         <= 1'b0;
            acc_r       <= '0;
            acc_count_r <= '0;
            acc_ovf_r   <= 1'b0;
            acc_valid_r <= 1'b0;
        end else begin
            if (state == HOLD && bus.acc_ready) begin
                acc_valid_r <= 1'b0;
                state       <= COLLECT;
            end
            // A closing product overrides the retire above and re-enters HOLD.
            if (accept) begin
                if (bus.prod_last) begin
                    acc_r       <= sum_nxt;
                    acc_count_r <= cnt_nxt;
                    acc_ovf_r   <= ovf_nxt;
                    acc_valid_r <= 1'b1;
                    state       <= HOLD;
                    sum         <= '0;
                    cnt         <= '0;
                    ovf         <= 1'b0;
                end else begin
                    sum <= sum_nxt;
                    cnt <= cnt_nxt;
                    ovf <= ovf_nxt;
                end
            end
        end
    end

    assign bus.acc       = acc_r;
    assign bus.acc_count = acc_count_r;
    assign bus.acc_ovf   = acc_ovf_r;
    assign bus.acc_valid = acc_valid_r;
endmodule

// File: tb/tb_wallace_acc.sv
// Directed bench for wallace_acc: default build plus a narrow ACC_W=33/CNT_W=2
// build for the wrap and count-saturation cases.
module tb_wallace_acc;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    wallace_acc_if #(.ACC_W(40), .CNT_W(8)) ia ();
    wallace_acc_if #(.ACC_W(33), .CNT_W(2)) ib ();

    wallace_acc #(.ACC_W(40), .CNT_W(8)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
    wallace_acc #(.ACC_W(33), .CNT_W(2)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic a_drive(input logic v, input logic [31:0] p, input logic l, input logic r);
        @(negedge clk);
        ia.prod_valid = v;
        ia.prod       = p;
        ia.prod_last  = l;
        ia.acc_ready  = r;
    endtask

    task automatic b_drive(input logic v, input logic [31:0] p, input logic l, input logic r);
        @(negedge clk);
        ib.prod_valid = v;
        ib.prod       = p;
        ib.prod_last  = l;
        ib.acc_ready  = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        ia.prod_valid = 1'b0; ia.prod = '0; ia.prod_last = 1'b0; ia.acc_ready = 1'b0;
        ib.prod_valid = 1'b0; ib.prod = '0; ib.prod_last = 1'b0; ib.acc_ready = 1'b0;

        tick(); tick();
        check("rst_valid", 64'(ia.acc_valid), 64'd0);
        check("rst_acc", 64'(ia.acc), 64'd0);
        check("rst_count", 64'(ia.acc_count), 64'd0);
        check("rst_ovf", 64'(ia.acc_ovf), 64'd0);
        check("rst_ready", 64'(ia.prod_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;

        // single-product vector
        a_drive(1'b1, 32'd2862750, 1'b1, 1'b0); tick();
        check("one_valid", 64'(ia.acc_valid), 64'd1);
        check("one_acc", 64'(ia.acc), 64'd2862750);
        check("one_count", 64'(ia.acc_count), 64'd1);
        check("one_ovf", 64'(ia.acc_ovf), 64'd0);
        check("one_hold_ready", 64'(ia.prod_ready), 64'd0);
        a_drive(1'b0, 32'd0, 1'b0, 1'b1); tick();
        check("one_retired", 64'(ia.acc_valid), 64'd0);

        // three back-to-back products
        a_drive(1'b1, 32'd2862750, 1'b0, 1'b1); tick();
        a_drive(1'b1, 32'd352000, 1'b0, 1'b1); tick();
        check("three_mid_valid", 64'(ia.acc_valid), 64'd0);
        a_drive(1'b1, 32'd0, 1'b1, 1'b1); tick();
        check("three_valid", 64'(ia.acc_valid), 64'd1);
        check("three_acc", 64'(ia.acc), 64'd3214750);
        check("three_count", 64'(ia.acc_count), 64'd3);
        check("three_ovf", 64'(ia.acc_ovf), 64'd0);
        a_drive(1'b0, 32'd0, 1'b0, 1'b1); tick();
        check("three_one_cycle", 64'(ia.acc_valid), 64'd0);

        // backpressure, with a pending product that must not be taken
        a_drive(1'b1, 32'd4351360, 1'b0, 1'b0); tick();
        a_drive(1'b1, 32'd207835, 1'b1, 1'b0); tick();
        check("bp_acc", 64'(ia.acc), 64'd4559195);
        for (int i = 0; i < 5; i++) begin
            a_drive(1'b1, 32'd999, 1'b1, 1'b0); tick();
            check("bp_ready", 64'(ia.prod_ready), 64'd0);
            check("bp_valid", 64'(ia.acc_valid), 64'd1);
            check("bp_stable", 64'(ia.acc), 64'd4559195);
            check("bp_count", 64'(ia.acc_count), 64'd2);
        end
        a_drive(1'b1, 32'd124118316, 1'b0, 1'b1);
        #1;
        check("bp_release_ready", 64'(ia.prod_ready), 64'd1);
        tick();
        check("bp_release_valid", 64'(ia.acc_valid), 64'd0);
        a_drive(1'b1, 32'd683280, 1'b1, 1'b1); tick();
        check("bp2_valid", 64'(ia.acc_valid), 64'd1);
        check("bp2_acc", 64'(ia.acc), 64'd124801596);
        check("bp2_count", 64'(ia.acc_count), 64'd2);

        // length-1 vector taken while the previous result retires
        a_drive(1'b1, 32'd5, 1'b1, 1'b1); tick();
        check("hold_reload_valid", 64'(ia.acc_valid), 64'd1);
        check("hold_reload_acc", 64'(ia.acc), 64'd5);
        check("hold_reload_count", 64'(ia.acc_count), 64'd1);
        a_drive(1'b0, 32'd0, 1'b0, 1'b1); tick();

        // reset mid-vector
        a_drive(1'b1, 32'd124118316, 1'b0, 1'b1); tick();
        a_drive(1'b1, 32'd683280, 1'b0, 1'b1); tick();
        a_drive(1'b0, 32'd0, 1'b0, 1'b1);
        rst = 1'b1;
        tick();
        check("midrst_valid", 64'(ia.acc_valid), 64'd0);
        check("midrst_acc", 64'(ia.acc), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        a_drive(1'b1, 32'd100210, 1'b1, 1'b1); tick();
        check("midrst_after_acc", 64'(ia.acc), 64'd100210);
        check("midrst_after_count", 64'(ia.acc_count), 64'd1);
        check("midrst_after_ovf", 64'(ia.acc_ovf), 64'd0);
        a_drive(1'b0, 32'd0, 1'b0, 1'b1);

        // sum wrap on the 33-bit build
        b_drive(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1); tick();
        b_drive(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1); tick();
        b_drive(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1); tick();
        check("wrap_acc", 64'(ib.acc), 64'h0_FFFF_FFFD);
        check("wrap_count", 64'(ib.acc_count), 64'd3);
        check("wrap_ovf", 64'(ib.acc_ovf), 64'd1);
        b_drive(1'b1, 32'd7, 1'b1, 1'b1); tick();
        check("wrap_next_acc", 64'(ib.acc), 64'd7);
        check("wrap_next_ovf", 64'(ib.acc_ovf), 64'd0);

        // count saturation with a 2-bit counter
        for (int i = 0; i < 5; i++) begin
            b_drive(1'b1, 32'd1, (i == 4), 1'b1); tick();
        end
        check("sat_acc", 64'(ib.acc), 64'd5);
        check("sat_count", 64'(ib.acc_count), 64'd3);
        check("sat_ovf", 64'(ib.acc_ovf), 64'd1);
        b_drive(1'b0, 32'd0, 1'b0, 1'b1); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wallace_acc.md
# wallace_acc

Streaming product accumulator that sits directly downstream of `wallace_mul`. It consumes the 32-bit unsigned product `q` as a valid/ready stream and sums a variable-length vector of products, delimited by `prod_last`, into one wide accumulator. It presents the finished dot-product result on a registered valid/ready output. Typical use: an operand sequencer drives `wallace_mul` and feeds `q` in here to form dot products for a downstream consumer.

## Interface
- `ACC_W`, default 40: accumulator / result width in bits. Must be ≥ 32.
- `CNT_W`, default 8: width of the per-vector product counter.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `prod`  in  32  unsigned product, taken from `wallace_mul` output `q`.
- `prod_valid`  in  1  `prod`/`prod_last` are valid this cycle.
- `prod_last`  in  1  this product closes the current vector.
- `prod_ready`  out  1  block accepts a product this cycle.
- `acc`  out  ACC_W  finished vector sum.
- `acc_count`  out  CNT_W  number of products in `acc`.
- `acc_ovf`  out  1  sum wrapped or count saturated within this vector.
- `acc_valid`  out  1  result on `acc`/`acc_count`/`acc_ovf` is valid.
- `acc_ready`  in  1  downstream takes the result.

## Operation
- Two states:
  - COLLECT: summing a vector.
  - HOLD: presenting a result.
- Accept condition: `prod_valid && prod_ready`.
- `prod_ready` is combinational:
  - 1 in COLLECT.
  - In HOLD, equal to `acc_ready`, so a new vector can start in the same cycle the old result is taken.
- COLLECT, product accepted, `prod_last`=0:
  - sum ← sum + zero-extended `prod`, modulo 2^ACC_W.
  - cnt ← cnt+1, saturating at all-ones.
  - ovf ← ovf | carry-out | count-saturation.
- COLLECT, product accepted, `prod_last`=1:
  - Same update, but the results are written to the output registers `acc`, `acc_count`, `acc_ovf`.
  - Set `acc_valid`, go to HOLD.
  - Clear sum, cnt and ovf.
- HOLD, `acc_ready`=0: all outputs frozen, no product accepted.
- HOLD, `acc_ready`=1:
  - Result retired and `acc_valid` cleared.
  - If a product is accepted in the same cycle, it is processed as in COLLECT starting from a cleared sum.
  - If that product also has `prod_last`=1, the new result is loaded, `acc_valid` stays 1 and the state stays HOLD.
  - Otherwise go to COLLECT.
- Vector length 1 (first product has `prod_last`=1) is legal: `acc` = `prod`, `acc_count` = 1.
- A count saturates at 2^CNT_W−1 and sets `acc_ovf`. A sum carry out of bit ACC_W−1 sets `acc_ovf`, and `acc` holds the wrapped value.
- `prod_last` and `prod` are ignored when `prod_valid` is 0.

## Timing
- Reset (`rst`=1 at a clock edge):
  - State becomes COLLECT.
  - sum, cnt, ovf, `acc`, `acc_count`, `acc_ovf` and `acc_valid` all become 0.
  - Reset overrides any handshake in that cycle.
  - A partial vector or an un-taken result is discarded.
  - While `rst` is high, `prod_ready` still follows the state rule.
- Latency: `acc_valid` rises on the first edge after the `prod_last` product is accepted.
- Throughput: one product per cycle. The result handoff adds no bubble when `acc_ready` is held high.
- All outputs except `prod_ready` are registered. `acc`, `acc_count` and `acc_ovf` are stable while `acc_valid && !acc_ready`.
- `prod_ready` depends combinationally on `acc_ready` only in HOLD. Upstream must not make `prod_valid` depend on `prod_ready`.

## Test plan
- Single-product vector, default parameters: after reset, `prod`=2862750 (11451×250) with `prod_last`=1.
  -> next cycle `acc_valid`=1, `acc`=2862750, `acc_count`=1, `acc_ovf`=0.
- Three products back-to-back, last one flagged: 2862750, 352000, 0, with `acc_ready`=1.
  -> `acc`=3214750, `acc_count`=3, `acc_ovf`=0, with `acc_valid` high for exactly one cycle.
- Backpressure: complete the vector 4351360, 207835 (last), then hold `acc_ready`=0 for 5 cycles.
  - Required: `prod_ready`=0 and `acc`=4559195 stable throughout.
  - Then raise `acc_ready` with `prod_valid`=1, `prod`=124118316, `prod_last`=0 in the same cycle: that product is accepted.
  - Follow with 683280 (last) -> `acc`=124801596, `acc_count`=2.
- Sum overflow, `ACC_W`=33: three products of 0xFFFFFFFF, the third with `prod_last`=1.
  -> `acc`=0x0FFFFFFFD, `acc_count`=3, `acc_ovf`=1. The next vector's `acc_ovf` returns to 0.
- Count saturation, `CNT_W`=2: five products of value 1, the fifth with `prod_last`=1.
  -> `acc`=5, `acc_count`=3, `acc_ovf`=1.
- Reset mid-vector: accept 124118316 and 683280 (both not last), pulse `rst` for one cycle, then accept 100210 (last).
  -> `acc`=100210, `acc_count`=1, `acc_ovf`=0. During the reset cycle, `acc_valid`=0.
